// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and width helper
// for the seven-segment scan controller.
package seg7_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic       ANODE_OFF  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_scan_ctrl_lz.sv
// Combinational leading-zero blanker: zeros above the
// most significant non-zero digit become BLANK_CODE.
module seg7_lz_suppress
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    en_i,
  output logic [4*NUM_DIGITS-1:0] digits_o
);

  logic lead;

  always_comb begin
    digits_o = digits_i;
    lead     = en_i;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (digits_i[4*i +: 4] != 4'h0) begin
        lead = 1'b0;
      end else if (lead) begin
        digits_o[4*i +: 4] = BLANK_CODE;
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed N-digit seven-segment scan controller with
// frame-synchronous double buffering and blanking guard.
module seven_segment_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  input  logic                    lz_blank_en,
  output logic [3:0]              digit_out,
  output logic                    dot_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_start
);

  localparam int IW = idx_w(NUM_DIGITS);
  localparam int CW = idx_w(SLOT_CYCLES);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(SLOT_CYCLES - 1);

  localparam logic [DW-1:0] ALL_BLANK = {NUM_DIGITS{BLANK_CODE}};
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF =
    {NUM_DIGITS{ANODE_OFF}};

  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_dot_q, act_dot_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dot_q, pend_dot_d;
  logic                  pend_vld_q, pend_vld_d;

  logic [3:0]            digit_q, digit_d;
  logic                  dot_q, dot_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  fs_q, fs_d;

  logic          slot_start;
  logic          wrap;
  logic          copy;
  logic [DW-1:0] lz_dig;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    slot_start = 1'b0;
    wrap       = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLANK;
          idx_d      = '0;
          cnt_d      = '0;
          slot_start = 1'b1;
          wrap       = 1'b1;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_END) state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == SLOT_END) begin
            state_d    = BLANK;
            cnt_d      = '0;
            slot_start = 1'b1;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A load on the copy cycle bypasses pending so it lands in this frame.
  always_comb begin
    copy       = (state_q == IDLE) || wrap;
    act_dig_d  = act_dig_q;
    act_dot_d  = act_dot_q;
    pend_dig_d = load ? digits_in : pend_dig_q;
    pend_dot_d = load ? dots_in : pend_dot_q;
    pend_vld_d = pend_vld_q | load;
    if (copy) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_dig_d = digits_in;
        act_dot_d = dots_in;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_dot_d = pend_dot_q;
      end
    end
  end

  seg7_lz_suppress #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz (
    .digits_i(act_dig_d),
    .en_i    (lz_blank_en),
    .digits_o(lz_dig)
  );

  always_comb begin
    digit_d = digit_q;
    dot_d   = dot_q;
    if (!enable) begin
      digit_d = BLANK_CODE;
      dot_d   = 1'b0;
    end else if (slot_start) begin
      digit_d = lz_dig[4*idx_d +: 4];
      dot_d   = act_dot_d[idx_d];
    end
    anode_d = ANODES_OFF;
    if (state_d == SHOW) anode_d = ~(NUM_DIGITS'(1) << idx_d);
    fs_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      act_dig_q  <= ALL_BLANK;
      act_dot_q  <= '0;
      pend_dig_q <= ALL_BLANK;
      pend_dot_q <= '0;
      pend_vld_q <= 1'b0;
      digit_q    <= BLANK_CODE;
      dot_q      <= 1'b0;
      anode_q    <= ANODES_OFF;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      act_dig_q  <= act_dig_d;
      act_dot_q  <= act_dot_d;
      pend_dig_q <= pend_dig_d;
      pend_dot_q <= pend_dot_d;
      pend_vld_q <= pend_vld_d;
      digit_q    <= digit_d;
      dot_q      <= dot_d;
      anode_q    <= anode_d;
      fs_q       <= fs_d;
    end
  end

  assign digit_out   = digit_q;
  assign dot_out     = dot_q;
  assign anode_n     = anode_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Scoreboard bench: timeline reference model pushes expected
// outputs per cycle; a monitor pops and compares them.
module tb_seven_segment_scan_ctrl;

  localparam int N     = 4;
  localparam int SLOT  = 8;
  localparam int BLK   = 2;
  localparam int FRAME = N * SLOT;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic load;
  logic [4*N-1:0] digits_in;
  logic [N-1:0] dots_in;
  logic lz_blank_en;
  logic [3:0] digit_out;
  logic dot_out;
  logic [N-1:0] anode_n;
  logic frame_start;

  seven_segment_scan_ctrl #(
    .NUM_DIGITS  (N),
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .dots_in    (dots_in),
    .lz_blank_en(lz_blank_en),
    .digit_out  (digit_out),
    .dot_out    (dot_out),
    .anode_n    (anode_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic [3:0]   dig;
    logic         dot;
    logic         fs;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: time since scan start plus the displayed buffers.
  bit         running;
  int         m_t;
  logic [3:0] act[N];
  logic [3:0] pend[N];
  logic [N-1:0] act_dot, pend_dot;
  bit         pv;
  logic [3:0] e_dig;
  logic       e_dot;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [3:0] shown(input int s);
    int hi = 0;
    for (int i = 0; i < N; i++) if (act[i] != 4'h0) hi = i;
    if (lz_blank_en && s > hi) return 4'hF;
    return act[s];
  endfunction

  task automatic model_reset();
    running = 0;
    m_t = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = 4'hF;
      pend[i] = 4'hF;
    end
    act_dot = '0;
    pend_dot = '0;
    pv = 0;
    e_dig = 4'hF;
    e_dot = 1'b0;
  endtask

  task automatic model_step();
    bit was_idle;
    bit copy;
    int slot;
    int c;
    exp_t e;
    was_idle = !running;
    copy = was_idle || (enable && ((m_t + 1) % FRAME == 0));
    if (copy) begin
      if (load) begin
        for (int i = 0; i < N; i++) act[i] = digits_in[4*i +: 4];
        act_dot = dots_in;
      end else if (pv) begin
        act = pend;
        act_dot = pend_dot;
      end
      pv = 0;
    end
    if (load) begin
      for (int i = 0; i < N; i++) pend[i] = digits_in[4*i +: 4];
      pend_dot = dots_in;
      if (!copy) pv = 1;
    end
    if (!enable) begin
      running = 0;
      m_t = 0;
      e_dig = 4'hF;
      e_dot = 1'b0;
      e = '{an: '1, dig: 4'hF, dot: 1'b0, fs: 1'b0};
    end else begin
      m_t = was_idle ? 0 : m_t + 1;
      running = 1;
      slot = (m_t / SLOT) % N;
      c = m_t % SLOT;
      if (c == 0) begin
        e_dig = shown(slot);
        e_dot = act_dot[slot];
      end
      e.an = (c >= BLK) ? ~(N'(1) << slot) : '1;
      e.dig = e_dig;
      e.dot = e_dot;
      e.fs = (m_t % FRAME == 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int md, input int val);
    int n = 0;
    while ((m_t % md) != val && n < 200) begin
      tick();
      n++;
    end
    chk("wait_bound", 32'(n < 200), 32'd1);
  endtask

  task automatic do_load(input logic [4*N-1:0] d,
                         input logic [N-1:0] p);
    digits_in = d;
    dots_in = p;
    load = 1'b1;
    tick();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode_n), 32'(4'hF));
    chk("rst_digit", 32'(digit_out), 32'hF);
    chk("rst_dot", 32'(dot_out), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a new output word.
  initial begin
    exp_t e;
    bit prev_on = 0;
    logic [3:0] prev_dig = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("anode_n", 32'(anode_n), 32'(e.an));
        chk("digit_out", 32'(digit_out), 32'(e.dig));
        chk("dot_out", 32'(dot_out), 32'(e.dot));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
      end
      chk("anode_onehot0", 32'($onehot0(~anode_n)), 32'd1);
      if (prev_on && anode_n != '1)
        chk("digit_hold", 32'(digit_out), 32'(prev_dig));
      prev_on = (anode_n != '1);
      prev_dig = digit_out;
    end
  end

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    load = 1'b0;
    digits_in = '0;
    dots_in = '0;
    lz_blank_en = 1'b0;
    async_reset();

    enable = 1'b1;
    do_load(16'h1234, 4'b0100);
    ticks(2 * FRAME);

    run_until(FRAME, 10);
    do_load(16'h5678, 4'b0001);
    ticks(2 * FRAME);

    run_until(FRAME, FRAME - 1);
    do_load(16'h0987, 4'b1000);
    ticks(FRAME);

    lz_blank_en = 1'b1;
    do_load(16'h0050, 4'b1010);
    ticks(2 * FRAME);
    do_load(16'h0000, 4'b0000);
    ticks(2 * FRAME);
    lz_blank_en = 1'b0;

    run_until(FRAME, 2 * SLOT + 4);
    enable = 1'b0;
    ticks(3);
    enable = 1'b1;
    ticks(FRAME + 5);

    run_until(SLOT, 5);
    async_reset();
    ticks(FRAME + 3);
    do_load(16'h4321, 4'b0011);
    ticks(2 * FRAME);

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        digits_in = 16'($urandom);
        dots_in = 4'($urandom);
        if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
        load = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) lz_blank_en = ~lz_blank_en;
      if ($urandom_range(0, 149) == 0) begin
        enable = 1'b0;
        ticks($urandom_range(1, 5));
        enable = 1'b1;
      end
      tick();
    end
    ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
- Time-multiplexing scan controller for an N-digit common-anode seven-segment display.
- Cycles through digits and presents one BCD code plus dot enable per slot to a single registered per-digit segment driver.
- Drives active-low anodes, with a blanking guard at each slot start to hide driver latency and prevent ghosting.
- Double-buffers display data so updates land only on frame boundaries.
- Optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 2..8.
- SLOT_CYCLES, 100000: clk cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at slot start with all anodes off; must be at least 2 (covers the driver's 1-cycle register latency).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low = display dark.
- load  in  1  one-cycle pulse; captures digits_in and dots_in into the pending buffer.
- digits_in  in  4*NUM_DIGITS  BCD digits; [3:0] = digit 0 (rightmost, least significant).
- dots_in  in  NUM_DIGITS  decimal-point enables, bit i = digit i.
- lz_blank_en  in  1  leading-zero suppression enable.
- digit_out  out  4  BCD code to the segment driver; 4'hF = blank.
- dot_out  out  1  dot enable to the segment driver.
- anode_n  out  NUM_DIGITS  active-low anode selects; at most one bit low at any time.
- frame_start  out  1  one-cycle pulse at the first cycle of the digit-0 slot.

Behaviour:
- Reset values:
  - anode_n all 1s; digit_out 4'hF; dot_out 0; frame_start 0.
  - Active and pending buffers: all digits 4'hF, dots 0; pending_valid 0.
  - State IDLE; idx 0; slot_cnt 0.
- Buffers:
  - load sets the pending buffer and pending_valid.
  - Pending copies into the active buffer at each frame boundary (cycle where idx wraps to 0 and slot_cnt restarts) or on any cycle while in IDLE; the copy clears pending_valid.
  - load coincident with a frame boundary: the new data is used for that frame.
  - A second load before the boundary overwrites pending (last wins).
- States:
  - IDLE: anodes all off. enable=1 -> BLANK with idx=0, slot_cnt=0, frame_start pulses.
  - BLANK: anodes off; digit_out/dot_out already hold values for idx. When slot_cnt = BLANK_CYCLES-1 -> SHOW.
  - SHOW: anode_n[idx]=0. When slot_cnt = SLOT_CYCLES-1 -> BLANK with slot_cnt=0 and idx = idx+1, wrapping NUM_DIGITS-1 -> 0; the wrap is the frame boundary and pulses frame_start.
- Outputs and latency:
  - digit_out/dot_out are registered and update on the first cycle of each slot, so they are stable BLANK_CYCLES cycles before the anode asserts.
  - anode_n is registered; anode_n[idx] goes low on slot cycle BLANK_CYCLES and returns high on the first cycle of the next slot.
- Leading-zero suppression (lz_blank_en=1):
  - Scanning from digit NUM_DIGITS-1 downward, each digit equal to 0 is output as 4'hF until the first non-zero digit.
  - Digit 0 is never suppressed.
  - The dot is still passed for a suppressed digit.
  - Computed combinationally from the active buffer.
- Digit values 10..15 pass through unchanged; the driver blanks them.
- enable deasserted in any state: next cycle IDLE; anodes all 1s; digit_out 4'hF; counters cleared. Re-enable restarts at digit 0.
- rst asserted mid-operation: all registers return to reset values immediately; no partial slot resumes.

Decomposition:
- Shared package (seg7_pkg):
  - Constants BLANK_CODE=4'hF and ANODE_OFF level.
  - State encoding localparams IDLE/BLANK/SHOW.
  - Function clog2-based index width.
- One natural sub-module: seg7_lz_suppress, a combinational leading-zero blanker (active digits + enable -> masked digits).
- The existing per-digit driver is instantiated by the integrator, not inside this block.

Test Plan (NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2):
- Reset, enable=1, load digits 0x1234, dots 4'b0100 -> frame_start pulses every 32 cycles.
  - Per slot: digit_out 4, 3, 2, 1 at cycle 0 of each slot; anode_n 1110, 1101, 1011, 0111 on cycles 2..7; dot_out=1 only in the digit-2 slot.
- Load 0x5678 at cycle 10 of a frame -> current frame still shows 1234; next frame shows 5678.
  - Load exactly on the boundary cycle -> 5678 appears in that frame.
- lz_blank_en=1, digits 0x0050 -> digit 3 and digit 2 output 4'hF; digit 1 = 5; digit 0 = 0.
  - Digits 0x0000 -> digits 3..1 are F and digit 0 = 0.
- Drop enable mid-SHOW of digit 2 -> next cycle anode_n=1111, digit_out=F.
  - Re-enable -> frame_start pulses and scan restarts at digit 0.
- Assert rst asynchronously mid-slot -> outputs take reset values without waiting for a clock edge.
  - After release with enable=1, the displayed data is blank (F) until a load.
- Every cycle, assert: anode_n has at most one bit low.
  - Assert: digit_out is unchanged whenever any anode is low.
